// File: rtl/jtopl_pkg.sv
// Shared definitions for the OPL phase-generator register slice:
// slot count, register base addresses and slot/operator-offset mapping.
package jtopl_pkg;

  localparam int SLOTS = 18;

  localparam logic [7:0] REG_OP_BASE = 8'h20;  // MUL / VIB, 0x20-0x35
  localparam logic [7:0] REG_FNUM_LO = 8'hA0;  // fnum[7:0], 0xA0-0xA8
  localparam logic [7:0] REG_FNUM_HI = 8'hB0;  // fnum[9:8], block, kon
  localparam logic [7:0] REG_DVB     = 8'hBD;  // vibrato depth

  typedef struct packed {
    logic [3:0] ch;
    logic       op;
    logic [4:0] off;
  } slot_info_t;

  // slot s: group = s/6, sub = s%6, channel = group*3 + sub%3, op = sub/3
  function automatic slot_info_t slot_map(input logic [4:0] s);
    slot_info_t r;
    logic [1:0] grp;
    logic [2:0] sub;
    if (s >= 5'd12) begin
      grp = 2'd2;
      sub = 3'(s - 5'd12);
    end else if (s >= 5'd6) begin
      grp = 2'd1;
      sub = 3'(s - 5'd6);
    end else begin
      grp = 2'd0;
      sub = 3'(s);
    end
    r.op  = (sub >= 3'd3);
    r.ch  = 4'({grp, 1'b0}) + 4'(grp) + 4'(r.op ? sub - 3'd3 : sub);
    r.off = {grp, sub};
    return r;
  endfunction

  // Operator offsets: group*8 + sub, sub 0..5, at most 0x15
  function automatic logic op_offset_valid(input logic [4:0] off);
    return (off <= 5'h15) && (off[2:1] != 2'b11);
  endfunction

  function automatic logic [4:0] offset_to_slot(input logic [4:0] off);
    return 5'(off[4:3]) * 5'd6 + 5'(off[2:0]);
  endfunction

endpackage

// File: rtl/jtopl_slot_cnt.sv
// Mod-SLOTS_N operator slot counter. `slot` is the slot entered on the
// next `cen`; `slot0` flags that this is slot 0.
module jtopl_slot_cnt
  import jtopl_pkg::*;
#(
  parameter int SLOTS_N = SLOTS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  output logic [4:0] slot,
  output logic       slot0
);

  localparam logic [4:0] LAST = 5'(SLOTS_N - 1);

  // advance once per enable, wrap after the last slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      slot <= 5'd0;
    else if (cen)
      slot <= (slot == LAST) ? 5'd0 : slot + 5'd1;
  end

  assign slot0 = (slot == 5'd0);

endmodule

// File: rtl/jtopl_pg_regs.sv
// Phase-generator register file and slot reader.
// CPU writes through an index/data port; per-slot values are presented
// time-multiplexed: fnum/block/pms at stage I, mul/pg_rst at stage II.
// Optional macro JTOPL_PGREGS_DEBUG_EN adds a dbg_dout readback port.
module jtopl_pg_regs
  import jtopl_pkg::*;
#(
  parameter int CH = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cenop,
  input  logic       wr,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [9:0] fnum_I,
  output logic [2:0] block_I,
  output logic [2:0] pms_I,
  output logic [3:0] mul_II,
  output logic       pg_rst_II,
  output logic       slot0_I
`ifdef JTOPL_PGREGS_DEBUG_EN
  ,
  output logic [7:0] dbg_dout
`endif
);

  localparam int NSLOT = 2 * CH;

  // storage
  logic [7:0] idx;
  logic [9:0] fnum     [0:CH-1];
  logic [2:0] block    [0:CH-1];
  logic       kon      [0:CH-1];
  logic [3:0] mul      [0:NSLOT-1];
  logic       vib      [0:NSLOT-1];
  logic       kon_prev [0:NSLOT-1];
  logic       dvb;

  // index decode
  logic [4:0] idx_off;
  logic [4:0] idx_slot;
  logic [3:0] idx_ch;
  logic       idx_is_op, idx_is_lo, idx_is_hi, idx_is_dvb;
  logic       data_wr;

  assign idx_off    = idx[4:0];
  assign idx_slot   = offset_to_slot(idx_off);
  assign idx_ch     = idx[3:0];
  assign idx_is_op  = (idx[7:5] == REG_OP_BASE[7:5]) && op_offset_valid(idx_off);
  assign idx_is_lo  = (idx[7:4] == REG_FNUM_LO[7:4]) && (idx_ch < 4'(CH));
  assign idx_is_hi  = (idx[7:4] == REG_FNUM_HI[7:4]) && (idx_ch < 4'(CH));
  assign idx_is_dvb = (idx == REG_DVB);
  assign data_wr    = wr & addr;

  // index latch; persists across data writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idx <= 8'd0;
    else if (wr && !addr)
      idx <= din;
  end

  // per-channel registers: fnum, block, key-on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        fnum[i]  <= 10'd0;
        block[i] <= 3'd0;
        kon[i]   <= 1'b0;
      end
    end else if (data_wr && idx_is_lo) begin
      fnum[idx_ch][7:0] <= din;
    end else if (data_wr && idx_is_hi) begin
      fnum[idx_ch][9:8] <= din[1:0];
      block[idx_ch]     <= din[4:2];
      kon[idx_ch]       <= din[5];
    end
  end

  // per-operator registers: MUL and vibrato enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOT; i++) begin
        mul[i] <= 4'd0;
        vib[i] <= 1'b0;
      end
    end else if (data_wr && idx_is_op) begin
      mul[idx_slot] <= din[3:0];
      vib[idx_slot] <= din[6];
    end
  end

  // global vibrato depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dvb <= 1'b0;
    else if (data_wr && idx_is_dvb)
      dvb <= din[6];
  end

  // slot sequencing
  logic [4:0]  cur_slot;
  logic        cur_slot0;
  slot_info_t  cur_info;
  logic [4:0]  slot_I;
  logic [3:0]  ch_I;
  logic        valid_I;
  logic        unused_slot_info;

  jtopl_slot_cnt #(.SLOTS_N(NSLOT)) u_slot_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cenop),
    .slot  (cur_slot),
    .slot0 (cur_slot0)
  );

  assign cur_info         = slot_map(cur_slot);
  assign unused_slot_info = ^{cur_info.op, cur_info.off};

  // stage I: values of the slot being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fnum_I  <= 10'd0;
      block_I <= 3'd0;
      pms_I   <= 3'd0;
      slot0_I <= 1'b0;
      slot_I  <= 5'd0;
      ch_I    <= 4'd0;
      valid_I <= 1'b0;
    end else if (cenop) begin
      fnum_I  <= fnum[cur_info.ch];
      block_I <= block[cur_info.ch];
      pms_I   <= vib[cur_slot] ? {1'b1, dvb, 1'b0} : 3'b000;
      slot0_I <= cur_slot0;
      slot_I  <= cur_slot;
      ch_I    <= cur_info.ch;
      valid_I <= 1'b1;
    end
  end

  // stage II: multiplier and per-operator key-on edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_II    <= 4'd0;
      pg_rst_II <= 1'b0;
      for (int i = 0; i < NSLOT; i++)
        kon_prev[i] <= 1'b0;
    end else if (cenop && valid_I) begin
      mul_II           <= mul[slot_I];
      pg_rst_II        <= kon[ch_I] & ~kon_prev[slot_I];
      kon_prev[slot_I] <= kon[ch_I];
    end
  end

`ifdef JTOPL_PGREGS_DEBUG_EN
  // readback of the latched index in register format
  always_comb begin
    dbg_dout = 8'd0;
    if (idx_is_op)
      dbg_dout = {1'b0, vib[idx_slot], 2'b00, mul[idx_slot]};
    else if (idx_is_lo)
      dbg_dout = fnum[idx_ch][7:0];
    else if (idx_is_hi)
      dbg_dout = {2'b00, kon[idx_ch], block[idx_ch], fnum[idx_ch][9:8]};
    else if (idx_is_dvb)
      dbg_dout = {1'b0, dvb, 6'b000000};
  end
`endif

endmodule

// File: tb/tb_jtopl_pg_regs.sv
// Bench for jtopl_pg_regs: behavioural register/slot model feeding an
// expected-output queue, compared every clk at the falling edge.
module tb_jtopl_pg_regs;

  localparam int W = 22;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cenop = 1'b0;
  logic       wr = 1'b0;
  logic       addr = 1'b0;
  logic [7:0] din = 8'd0;
  logic [9:0] fnum_I;
  logic [2:0] block_I;
  logic [2:0] pms_I;
  logic [3:0] mul_II;
  logic       pg_rst_II;
  logic       slot0_I;
`ifdef JTOPL_PGREGS_DEBUG_EN
  logic [7:0] dbg_dout;
`endif

  jtopl_pg_regs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cenop     (cenop),
    .wr        (wr),
    .addr      (addr),
    .din       (din),
    .fnum_I    (fnum_I),
    .block_I   (block_I),
    .pms_I     (pms_I),
    .mul_II    (mul_II),
    .pg_rst_II (pg_rst_II),
    .slot0_I   (slot0_I)
`ifdef JTOPL_PGREGS_DEBUG_EN
    ,
    .dbg_dout  (dbg_dout)
`endif
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  string phase = "init";
  int rst_seen, s0_seen, pms6_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model
  logic [9:0] m_fnum[9];
  logic [2:0] m_block[9];
  logic       m_kon[9];
  logic [3:0] m_mul[18];
  logic       m_vib[18];
  logic       m_kprev[18];
  logic       m_dvb;
  logic [7:0] m_idx;
  int         m_slot, m_slot_I;
  bit         m_valid_I;
  logic [9:0] e_fnum;
  logic [2:0] e_block, e_pms;
  logic [3:0] e_mul;
  logic       e_rst, e_s0;

  function automatic int m_ch(input int s);
    return (s / 6) * 3 + (s % 6) % 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      m_fnum[i] = '0; m_block[i] = '0; m_kon[i] = 1'b0;
    end
    for (int i = 0; i < 18; i++) begin
      m_mul[i] = '0; m_vib[i] = 1'b0; m_kprev[i] = 1'b0;
    end
    m_dvb = 1'b0; m_idx = 8'd0; m_slot = 0; m_slot_I = 0; m_valid_I = 1'b0;
    e_fnum = '0; e_block = '0; e_pms = '0; e_mul = '0; e_rst = 1'b0; e_s0 = 1'b0;
  endtask

  task automatic model_step(input logic ce, input logic w, input logic a, input logic [7:0] d);
    int c, o, s;
    if (ce) begin
      if (m_valid_I) begin
        c = m_ch(m_slot_I);
        e_mul = m_mul[m_slot_I];
        e_rst = m_kon[c] & ~m_kprev[m_slot_I];
        m_kprev[m_slot_I] = m_kon[c];
      end
      c = m_ch(m_slot);
      e_fnum  = m_fnum[c];
      e_block = m_block[c];
      e_pms   = m_vib[m_slot] ? {1'b1, m_dvb, 1'b0} : 3'b000;
      e_s0    = (m_slot == 0);
      m_slot_I  = m_slot;
      m_valid_I = 1'b1;
      m_slot    = (m_slot + 1) % 18;
    end
    if (w && !a) begin
      m_idx = d;
    end else if (w && a) begin
      if (m_idx >= 8'h20 && m_idx <= 8'h35) begin
        o = int'(m_idx) - 32;
        if ((o % 8) < 6) begin
          s = (o / 8) * 6 + o % 8;
          m_mul[s] = d[3:0];
          m_vib[s] = d[6];
        end
      end else if (m_idx >= 8'hA0 && m_idx <= 8'hA8) begin
        c = int'(m_idx) - 160;
        m_fnum[c][7:0] = d;
      end else if (m_idx >= 8'hB0 && m_idx <= 8'hB8) begin
        c = int'(m_idx) - 176;
        m_fnum[c][9:8] = d[1:0];
        m_block[c]     = d[4:2];
        m_kon[c]       = d[5];
      end else if (m_idx == 8'hBD) begin
        m_dvb = d[6];
      end
    end
  endtask

  // driver: one clk, inputs driven at the falling edge, outputs checked at the next
  task automatic cycle(input logic ce, input logic w, input logic a, input logic [7:0] d);
    logic [W-1:0] got;
    cenop = ce; wr = w; addr = a; din = d;
    model_step(ce, w, a, d);
    exp_q.push_back({e_fnum, e_block, e_pms, e_mul, e_rst, e_s0});
    @(negedge clk);
    got = {fnum_I, block_I, pms_I, mul_II, pg_rst_II, slot0_I};
    if (ce) begin
      if (pg_rst_II) rst_seen++;
      if (slot0_I) s0_seen++;
      if (pms_I == 3'b110) pms6_seen++;
    end
    check(phase, 32'(got), 32'(exp_q.pop_front()));
  endtask

  task automatic run_cenop(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 1'b0, 8'd0);
      cycle(1'b1, 1'b0, 1'b0, 8'd0);
    end
  endtask

  task automatic wr_reg(input logic [7:0] idx, input logic [7:0] data);
    cycle(1'b0, 1'b1, 1'b0, idx);
    cycle(1'b0, 1'b1, 1'b1, data);
  endtask

  task automatic align_to(input int s);
    for (int i = 0; i < 18 && m_slot != s; i++) cycle(1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    cenop = 1'b0; wr = 1'b0; addr = 1'b0; din = 8'd0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outs", 32'({fnum_I, block_I, pms_I, mul_II, pg_rst_II, slot0_I}), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] ri;
    do_reset();

    phase = "idle_run";
    s0_seen = 0;
    run_cenop(36);
    check("slot0_pulses", s0_seen, 2);

    phase = "fnum_block";
    wr_reg(8'hA3, 8'h45);
    wr_reg(8'hB3, 8'h1E);
    run_cenop(20);
    align_to(9);
    cycle(1'b1, 1'b0, 1'b0, 8'd0);
    check("ch3_fnum", fnum_I, 10'h245);
    check("ch3_block", block_I, 3'd7);

    phase = "keyon";
    wr_reg(8'hB3, 8'h3E);
    rst_seen = 0;
    run_cenop(36);
    check("kon_pulses", rst_seen, 2);
    rst_seen = 0;
    run_cenop(18);
    check("kon_no_repeat", rst_seen, 0);

    phase = "keyoff_on_fast";
    wr_reg(8'hB3, 8'h1E);
    wr_reg(8'hB3, 8'h3E);
    rst_seen = 0;
    run_cenop(36);
    check("kon_blip_ignored", rst_seen, 0);

    phase = "keyoff_on_slow";
    wr_reg(8'hB3, 8'h1E);
    run_cenop(36);
    wr_reg(8'hB3, 8'h3E);
    rst_seen = 0;
    run_cenop(36);
    check("kon_pulses_again", rst_seen, 2);

    phase = "vib_mul";
    wr_reg(8'h2C, 8'h4A);
    wr_reg(8'hBD, 8'h40);
    pms6_seen = 0;
    run_cenop(18);
    check("pms_110_count", pms6_seen, 1);
    run_cenop(18);

    phase = "invalid_idx";
    wr_reg(8'h26, 8'h0F);
    wr_reg(8'hA9, 8'hFF);
    wr_reg(8'h3F, 8'h0F);
    run_cenop(40);

    phase = "collision";
    align_to(0);
    cycle(1'b0, 1'b1, 1'b0, 8'hA0);
    cycle(1'b1, 1'b1, 1'b1, 8'h77);
    check("coll_fnum_old", fnum_I, 10'h000);
    cycle(1'b0, 1'b1, 1'b0, 8'h20);
    cycle(1'b1, 1'b1, 1'b1, 8'h05);
    check("coll_mul_old", mul_II, 4'h0);
    run_cenop(17);
    check("coll_fnum_new", fnum_I, 10'h077);
    check("coll_slot0", slot0_I, 1'b1);
    run_cenop(1);
    check("coll_mul_new", mul_II, 4'h5);

    phase = "random";
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          case ($urandom_range(0, 4))
            0: ri = 8'h20 + 8'($urandom_range(0, 21));
            1: ri = 8'hA0 + 8'($urandom_range(0, 9));
            2: ri = 8'hB0 + 8'($urandom_range(0, 9));
            3: ri = 8'hBD;
            default: ri = 8'($urandom_range(0, 255));
          endcase
          cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, ri);
        end
        1: cycle(1'($urandom_range(0, 1)), 1'b1, 1'b1, 8'($urandom_range(0, 255)));
        default: cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'd0);
      endcase
    end
    run_cenop(40);

    phase = "mid_reset";
    run_cenop(7);
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'd0);
    check("restart_slot0", slot0_I, 1'b1);
    run_cenop(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
